// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC generation, credit-limited memory requests, 2-entry
// response buffer toward decode, and redirect flushing of queued and in-flight words.
module fetch_unit #(
  parameter int unsigned    N        = 32,
  parameter logic [N-1:0]   RESET_PC = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  output logic         o_imem_req,
  output logic [N-1:0] o_imem_addr,
  input  logic         i_imem_rvalid,
  input  logic [N-1:0] i_imem_rdata,
  input  logic         i_redirect,
  input  logic [N-1:0] i_redirect_pc,
  output logic         o_id_valid,
  input  logic         i_id_ready,
  output logic [N-1:0] o_id_instr,
  output logic [N-1:0] o_id_pc,
  output logic [N-1:0] o_id_pc_plus4
);

  localparam logic [N-1:0] PcStep = N'(4);

  logic [N-1:0] r_pc;
  logic [N-1:0] r_buf_pc    [2];
  logic [N-1:0] r_buf_instr [2];
  logic         r_buf_head;
  logic [1:0]   r_count;
  logic [N-1:0] r_tag       [2];
  logic         r_tag_head;
  logic [1:0]   r_infl;
  logic [1:0]   r_drop;

  logic         w_req;
  logic         w_resp;
  logic         w_push;
  logic         w_pop;
  logic         w_id_valid;
  logic         w_buf_wr;
  logic         w_tag_wr;
  logic [N-1:0] w_tag;
  logic [1:0]   w_count_nxt;
  logic [1:0]   w_infl_nxt;
  logic         w_unused_pc_lsb;

  assign w_unused_pc_lsb = ^i_redirect_pc[1:0];

  // Credit is taken from registered occupancy only, so a pop this cycle frees no slot yet.
  assign w_req      = !i_rst && !i_redirect && (({1'b0, r_count} + {1'b0, r_infl}) < 3'd2);
  assign w_resp     = !i_rst && i_imem_rvalid && (r_infl != 2'd0);
  assign w_push     = w_resp && (r_drop == 2'd0) && !i_redirect;
  assign w_id_valid = !i_rst && (r_count != 2'd0) && !i_redirect;
  assign w_pop      = w_id_valid && i_id_ready;

  assign w_buf_wr = r_buf_head ^ r_count[0];
  assign w_tag_wr = r_tag_head ^ r_infl[0];
  assign w_tag    = r_tag[r_tag_head];

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 2'd1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 2'd1;
    end
  end

  always_comb begin
    w_infl_nxt = r_infl;
    if (w_req && !w_resp) begin
      w_infl_nxt = r_infl + 2'd1;
    end else if (!w_req && w_resp) begin
      w_infl_nxt = r_infl - 2'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc       <= RESET_PC;
      r_buf_head <= 1'b0;
      r_count    <= 2'd0;
      r_tag_head <= 1'b0;
      r_infl     <= 2'd0;
      r_drop     <= 2'd0;
    end else begin
      r_infl <= w_infl_nxt;
      if (w_resp) begin
        r_tag_head <= ~r_tag_head;
      end
      if (i_redirect) begin
        r_pc       <= {i_redirect_pc[N-1:2], 2'b00};
        r_buf_head <= 1'b0;
        r_count    <= 2'd0;
        // r_drop is already a subset of r_infl, so every word still in flight is stale.
        r_drop     <= r_infl - {1'b0, w_resp};
      end else begin
        if (w_req) begin
          r_pc <= r_pc + PcStep;
        end
        if (w_resp && (r_drop != 2'd0)) begin
          r_drop <= r_drop - 2'd1;
        end
        if (w_pop) begin
          r_buf_head <= ~r_buf_head;
        end
        r_count <= w_count_nxt;
      end
    end
  end

  // Payload storage needs no reset; occupancy counters gate every read.
  always_ff @(posedge i_clk) begin
    if (w_req) begin
      r_tag[w_tag_wr] <= r_pc;
    end
    if (w_push) begin
      r_buf_pc[w_buf_wr]    <= w_tag;
      r_buf_instr[w_buf_wr] <= i_imem_rdata;
    end
  end

  assign o_imem_req    = w_req;
  assign o_imem_addr   = r_pc;
  assign o_id_valid    = w_id_valid;
  assign o_id_pc       = r_buf_pc[r_buf_head];
  assign o_id_instr    = r_buf_instr[r_buf_head];
  assign o_id_pc_plus4 = r_buf_pc[r_buf_head] + PcStep;

endmodule
